contador_mod16: RTL and testbench
=================================

// Module: contador_mod16
// PURPOSE
//   4-bit synchronous up-counter, modulo 16 (0..15, wraps to 0).
//   Rising-edge clocked, async clear, synchronous preset to all-ones.
//   General-purpose count/sequence source for sequential-logic datapaths.
//
// PARAMETERS
//   WIDTH         4      counter width in bits; modulus = 2**WIDTH
//   PRESET_VALUE  4'hF   value loaded by preset (all ones)
//
// PORTS
//   clock    in   1      rising-edge clock
//   reset    in   1      asynchronous, active-low clear
//   preset   in   1      synchronous, active-high load of PRESET_VALUE
//   counter  out  WIDTH  registered count value
//
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low.
//   - reset==0: counter <= 0 immediately, independent of clock.
//     Held at 0 for as long as reset==0; preset and clock ignored.
//   - Release of reset (0->1) causes no count; first increment occurs
//     at the first rising clock edge after release.
//   - Rising clock edge, reset==1, preset==1: counter <= PRESET_VALUE.
//   - Rising clock edge, reset==1, preset==0: counter <= counter + 1,
//     modulo 2**WIDTH (15 -> 0, no carry/saturation).
//   - Priority: reset > preset > increment.
//   - Preset is sampled only at rising edges; latency one edge.
//     Preset active for N edges holds counter at PRESET_VALUE; next edge
//     with preset==0 wraps it to 0.
//   - Output is a pure register (no combinational path from inputs),
//     except the asynchronous reset path.
//   - Falling clock edges have no effect.
//   - Power-up value undefined until first reset assertion.
//
// TESTING
//   1. reset=0 for 25ns, clock toggling -> counter==0 throughout;
//      assert reset mid-count (e.g. counter==9) -> counter==0 at once,
//      without waiting for a clock edge.
//   2. reset=1, preset=0, 15 rising edges -> counter steps 0,1..15,
//      one increment per rising edge, none on falling edges.
//   3. Continue from 15: one more rising edge -> counter==0 (wrap);
//      counting then resumes 1,2,...
//   4. After reset, count to 2, then preset=1 at next rising edge ->
//      counter==15; preset=0 next edge -> counter==0.
//   5. Preset held high for 3 edges -> counter stays 15; reset=0
//      while preset=1 -> counter==0 (reset priority).
//   6. Release reset between edges -> no change until next rising
//      edge, then counter==1.

Source files
------------

// File: rtl/contador_mod16.sv
// Modulo-2**WIDTH synchronous up-counter with asynchronous active-low clear
// and synchronous preset to PRESET_VALUE.
module contador_mod16 #(
    parameter int unsigned          WIDTH        = 4,
    parameter logic [WIDTH-1:0]     PRESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             preset,
    output logic [WIDTH-1:0] counter
);

    localparam int unsigned STEP = 1;

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;

    // Preset outranks increment; the increment wraps naturally at 2**WIDTH.
    always_comb begin
        w_count_nxt = r_count + WIDTH'(STEP);
        if (preset) begin
            w_count_nxt = PRESET_VALUE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign counter = r_count;

endmodule

// File: tb/tb_contador_mod16.sv
// Directed self-checking bench for contador_mod16: clear, count, wrap,
// preset, reset priority and reset release between clock edges.
module tb_contador_mod16;

    logic       clock;
    logic       reset;
    logic       preset;
    logic [3:0] counter;

    int n_cmp;
    int n_err;

    contador_mod16 dut (
        .clock   (clock),
        .reset   (reset),
        .preset  (preset),
        .counter (counter)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        preset = 1'b0;
        #1;
        n_cmp++;
        if (counter !== 4'd0) begin
            n_err++;
            $display("FAIL reset_initial: got %0d expected 0", counter);
        end
        // Clock keeps running for ~25ns with reset low.
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (counter !== 4'd0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: got %0d expected 0", i, counter);
            end
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        n_cmp++;
        if (counter !== 4'd9) begin
            n_err++;
            $display("FAIL reset_count_to_9: got %0d expected 9", counter);
        end
        // Assert reset between edges; clear must not wait for a clock.
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (counter !== 4'd0) begin
            n_err++;
            $display("FAIL reset_async_clear: got %0d expected 0", counter);
        end
    endtask

    task automatic test_count();
        reset  = 1'b0;
        preset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (counter !== 4'd0) begin
            n_err++;
            $display("FAIL count_after_release: got %0d expected 0", counter);
        end
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_cmp++;
            if (counter !== 4'(i)) begin
                n_err++;
                $display("FAIL count_rise[%0d]: got %0d expected %0d", i, counter, i);
            end
            @(negedge clock);
            #1;
            n_cmp++;
            if (counter !== 4'(i)) begin
                n_err++;
                $display("FAIL count_fall[%0d]: got %0d expected %0d", i, counter, i);
            end
        end
    endtask

    task automatic test_wrap();
        tick();
        n_cmp++;
        if (counter !== 4'd0) begin
            n_err++;
            $display("FAIL wrap_15_to_0: got %0d expected 0", counter);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if (counter !== 4'(i)) begin
                n_err++;
                $display("FAIL wrap_resume[%0d]: got %0d expected %0d", i, counter, i);
            end
        end
    endtask

    task automatic test_preset();
        @(negedge clock);
        reset  = 1'b0;
        preset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (counter !== 4'd2) begin
            n_err++;
            $display("FAIL preset_count_to_2: got %0d expected 2", counter);
        end
        @(negedge clock);
        preset = 1'b1;
        tick();
        n_cmp++;
        if (counter !== 4'd15) begin
            n_err++;
            $display("FAIL preset_load: got %0d expected 15", counter);
        end
        @(negedge clock);
        preset = 1'b0;
        tick();
        n_cmp++;
        if (counter !== 4'd0) begin
            n_err++;
            $display("FAIL preset_then_wrap: got %0d expected 0", counter);
        end
    endtask

    task automatic test_preset_hold();
        tick();
        @(negedge clock);
        preset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (counter !== 4'd15) begin
                n_err++;
                $display("FAIL preset_hold[%0d]: got %0d expected 15", i, counter);
            end
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (counter !== 4'd0) begin
            n_err++;
            $display("FAIL reset_over_preset_async: got %0d expected 0", counter);
        end
        tick();
        n_cmp++;
        if (counter !== 4'd0) begin
            n_err++;
            $display("FAIL reset_over_preset_edge: got %0d expected 0", counter);
        end
        @(negedge clock);
        preset = 1'b0;
    endtask

    task automatic test_release();
        reset  = 1'b0;
        preset = 1'b0;
        tick();
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (counter !== 4'd0) begin
            n_err++;
            $display("FAIL release_no_change: got %0d expected 0", counter);
        end
        @(negedge clock);
        #1;
        n_cmp++;
        if (counter !== 4'd0) begin
            n_err++;
            $display("FAIL release_fall_edge: got %0d expected 0", counter);
        end
        tick();
        n_cmp++;
        if (counter !== 4'd1) begin
            n_err++;
            $display("FAIL release_first_edge: got %0d expected 1", counter);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b0;
        preset = 1'b0;
        test_reset();
        test_count();
        test_wrap();
        test_preset();
        test_preset_hold();
        test_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
